// File: rtl/fpu_round_pipe.sv
// Two-stage IEEE-754 round-and-pack unit: stage 1 applies the rounding increment,
// stage 2 handles overflow saturation, subnormal packing, special bypass and flags.
module fpu_round_pipe #(
  parameter int EXP = 8,
  parameter int MAN = 23
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP:0]     in_exp,
  input  logic [MAN:0]     in_mant,
  input  logic [2:0]       in_grs,
  input  logic [2:0]       in_frm,
  input  logic             in_nx,
  input  logic             in_zero_exact,
  input  logic             in_special,
  input  logic [EXP+MAN:0] in_special_result,
  input  logic [4:0]       in_special_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP+MAN:0] out_result,
  output logic [4:0]       out_flags,
  input  logic             flags_clr,
  output logic [4:0]       flags_acc
);

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } frm_e;

  logic s1_valid, s2_valid, s1_en, s2_en;

  assign s2_en     = ~s2_valid | out_ready;
  assign s1_en     = ~s1_valid | s2_en;
  assign in_ready  = s1_en & rst_l;
  assign out_valid = s2_valid;

  // ---------------- stage 1: rounding increment ----------------
  logic           any_grs, rnd_up, frm_bad;
  logic [MAN+1:0] mant_sum;
  logic [MAN:0]   m_next;
  logic [EXP:0]   e_next;

  always_comb begin
    rnd_up  = 1'b0;
    frm_bad = 1'b0;
    any_grs = |in_grs;
    case (in_frm)
      RNE:     rnd_up = in_grs[2] & (in_grs[1] | in_grs[0] | in_mant[0]);
      RTZ:     rnd_up = 1'b0;
      RDN:     rnd_up = in_sign & any_grs;
      RUP:     rnd_up = ~in_sign & any_grs;
      RMM:     rnd_up = in_grs[2];
      default: frm_bad = 1'b1;
    endcase
    mant_sum = {1'b0, in_mant} + {{(MAN+1){1'b0}}, rnd_up};
    // A carry out of the mantissa renormalises by one place and bumps the exponent.
    m_next = mant_sum[MAN+1] ? mant_sum[MAN+1:1] : mant_sum[MAN:0];
    e_next = in_exp + {{EXP{1'b0}}, mant_sum[MAN+1]};
  end

  logic             s1_sign, s1_inexact, s1_nv, s1_zero, s1_special;
  logic [2:0]       s1_frm;
  logic [EXP:0]     s1_e;
  logic [MAN:0]     s1_m;
  logic [EXP+MAN:0] s1_sres;
  logic [4:0]       s1_sflags;

  always_ff @(posedge clk) begin
    if (in_valid && s1_en) begin
      s1_sign    <= in_sign;
      s1_frm     <= in_frm;
      s1_e       <= e_next;
      s1_m       <= m_next;
      s1_inexact <= any_grs | in_nx;
      s1_nv      <= frm_bad;
      s1_zero    <= in_zero_exact;
      s1_special <= in_special;
      s1_sres    <= in_special_result;
      s1_sflags  <= in_special_flags;
    end
  end

  // ---------------- stage 2: pack ----------------
  logic             ovf, to_inf, normal, res_sign;
  logic [EXP+MAN:0] res;
  logic [4:0]       flags;

  always_comb begin
    ovf      = s1_e[EXP] | (&s1_e[EXP-1:0]);
    normal   = s1_m[MAN];
    to_inf   = 1'b0;
    res_sign = s1_sign;
    res      = '0;
    flags    = '0;
    case (s1_frm)
      RNE, RMM: to_inf = 1'b1;
      RUP:      to_inf = ~s1_sign;
      RDN:      to_inf = s1_sign;
      default:  to_inf = 1'b0;
    endcase
    if (s1_special) begin
      res   = s1_sres;
      flags = s1_sflags;
    end else if (ovf) begin
      res   = to_inf ? {s1_sign, {EXP{1'b1}}, {MAN{1'b0}}}
                     : {s1_sign, {(EXP-1){1'b1}}, 1'b0, {MAN{1'b1}}};
      flags = {s1_nv, 1'b0, 1'b1, 1'b0, 1'b1};
    end else begin
      // Exact cancellation to zero takes its sign from the rounding mode.
      if (s1_zero && !normal && (s1_m[MAN-1:0] == '0))
        res_sign = (s1_frm == RDN);
      res   = {res_sign, (normal ? s1_e[EXP-1:0] : {EXP{1'b0}}), s1_m[MAN-1:0]};
      flags = {s1_nv, 1'b0, 1'b0, ~normal & s1_inexact, s1_inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (s1_en) s1_valid <= in_valid;
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res;
          out_flags  <= flags;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l)
      flags_acc <= '0;
    else if (flags_clr)
      flags_acc <= (out_valid && out_ready) ? out_flags : '0;
    else if (out_valid && out_ready)
      flags_acc <= flags_acc | out_flags;
  end

endmodule

// File: tb/tb_fpu_round_pipe.sv
// Bench for fpu_round_pipe: directed vectors plus randomized traffic with
// backpressure, scored against an arithmetic reference model.
module tb_fpu_round_pipe;

  localparam int EXP = 8;
  localparam int MAN = 23;
  localparam int W   = EXP + MAN + 1;

  typedef struct packed {
    logic         sign;
    logic [EXP:0] exp;
    logic [MAN:0] mant;
    logic [2:0]   grs;
    logic [2:0]   frm;
    logic         nx;
    logic         zero;
    logic         special;
    logic [W-1:0] sres;
    logic [4:0]   sflags;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_l;
  logic         in_valid, in_ready;
  logic         in_sign, in_nx, in_zero_exact, in_special;
  logic [EXP:0] in_exp;
  logic [MAN:0] in_mant;
  logic [2:0]   in_grs, in_frm;
  logic [W-1:0] in_special_result;
  logic [4:0]   in_special_flags;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_flags;
  logic         flags_clr;
  logic [4:0]   flags_acc;

  fpu_round_pipe #(.EXP(EXP), .MAN(MAN)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
    .in_frm(in_frm), .in_nx(in_nx), .in_zero_exact(in_zero_exact),
    .in_special(in_special), .in_special_result(in_special_result),
    .in_special_flags(in_special_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .flags_clr(flags_clr), .flags_acc(flags_acc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp_v, $time);
    end
  endtask

  // Reference: rounding and packing done with plain integer arithmetic.
  function automatic logic [W+4:0] ref_model(input beat_t b);
    longint unsigned m, e, res;
    bit any, up, nv, ovf, to_inf, normal, inexact, sgn;
    int unsigned fl;
    if (b.special) return {b.sres, b.sflags};
    any = |b.grs; up = 0; nv = 0;
    case (b.frm)
      3'd0: up = b.grs[2] && (b.grs[1] || b.grs[0] || b.mant[0]);
      3'd1: up = 0;
      3'd2: up = b.sign && any;
      3'd3: up = !b.sign && any;
      3'd4: up = b.grs[2];
      default: nv = 1;
    endcase
    m = longint'(b.mant) + longint'(up);
    e = longint'(b.exp);
    if (m >= (64'd1 << (MAN + 1))) begin
      m = m >> 1;
      e = e + 1;
    end
    e = e % (64'd1 << (EXP + 1));
    inexact = any || b.nx;
    ovf = (e >= (64'd1 << EXP) - 1);
    sgn = b.sign;
    if (ovf) begin
      to_inf = (b.frm == 3'd0) || (b.frm == 3'd4) || (b.frm == 3'd3 && !b.sign) ||
               (b.frm == 3'd2 && b.sign);
      res = to_inf ? (((64'd1 << EXP) - 1) << MAN)
                   : ((((64'd1 << EXP) - 2) << MAN) + (64'd1 << MAN) - 1);
      fl = (nv ? 16 : 0) + 4 + 1;
    end else begin
      normal = (m >= (64'd1 << MAN));
      res = ((normal ? e : 64'd0) << MAN) + (m % (64'd1 << MAN));
      if (b.zero && res == 0) sgn = (b.frm == 3'd2);
      fl = (nv ? 16 : 0) + ((!normal && inexact) ? 2 : 0) + (inexact ? 1 : 0);
    end
    res = res + (longint'(sgn) << (EXP + MAN));
    return {res[W-1:0], fl[4:0]};
  endfunction

  function automatic beat_t mk(input logic s, input int unsigned e, input logic [MAN:0] m,
                               input logic [2:0] grs, input logic [2:0] frm);
    beat_t b = '0;
    b.sign = s; b.exp = e[EXP:0]; b.mant = m; b.grs = grs; b.frm = frm;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b = '0;
    logic [31:0] r;
    int unsigned sel;
    r = $urandom;
    b.sign = r[0];
    b.grs  = r[3:1];
    b.frm  = ($urandom % 8 == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
    b.nx   = ($urandom % 8 == 0);
    b.mant = MAN'($urandom);
    sel = $urandom % 16;
    if (sel < 10) begin
      b.exp = (EXP+1)'(1 + $urandom % 254);
      b.mant[MAN] = 1'b1;
    end else if (sel < 12) begin
      b.exp = 1;
      b.mant[MAN] = 1'b0;
      if ($urandom % 2 == 0) b.mant[MAN-1:0] = '1;
    end else if (sel < 13) begin
      b.exp = (EXP+1)'(255 + $urandom % 2);
      b.mant[MAN] = 1'b1;
    end else if (sel < 14) begin
      b.exp = 254;
      b.mant = '1;
    end else if (sel < 15) begin
      b.exp = 1; b.mant = '0; b.grs = '0; b.nx = 0; b.zero = 1;
    end else begin
      b.special = 1;
      b.sres    = $urandom;
      b.sflags  = 5'($urandom);
    end
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_sign = b.sign; in_exp = b.exp; in_mant = b.mant; in_grs = b.grs;
    in_frm = b.frm; in_nx = b.nx; in_zero_exact = b.zero; in_special = b.special;
    in_special_result = b.sres; in_special_flags = b.sflags;
  endtask

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input beat_t b);
    int unsigned n = 0;
    drive(b);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Single beat through an idle, unstalled pipe: checks 2-cycle latency and value.
  task automatic run_vec(input string tag, input beat_t b, input logic [W-1:0] res,
                         input logic [4:0] fl, input logic clr);
    send(b);
    @(negedge clk);
    check({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    flags_clr = clr;
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, out_result, res);
    check({tag, "_flags"}, out_flags, fl);
    @(posedge clk); #1;
    flags_clr = 1'b0;
  endtask

  // Scoreboard and accumulator model, sampled on the falling edge.
  logic [W+4:0] sb_q[$];
  logic [4:0]   model_acc = '0;

  always @(negedge clk) begin
    logic [W+4:0] exp_v;
    logic [4:0]   hf;
    beat_t        cur;
    check("flags_acc", flags_acc, model_acc);
    if (!rst_l) begin
      sb_q.delete();
      model_acc = '0;
    end else begin
      hf = '0;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          exp_v = sb_q[0];
          check("sb_result", out_result, exp_v[W+4:5]);
          check("sb_flags", out_flags, exp_v[4:0]);
          if (out_ready) begin
            hf = exp_v[4:0];
            void'(sb_q.pop_front());
          end
        end
      end
      model_acc = flags_clr ? hf : (model_acc | hf);
      if (in_valid && in_ready) begin
        cur = '0;
        cur.sign = in_sign; cur.exp = in_exp; cur.mant = in_mant; cur.grs = in_grs;
        cur.frm = in_frm; cur.nx = in_nx; cur.zero = in_zero_exact;
        cur.special = in_special; cur.sres = in_special_result;
        cur.sflags = in_special_flags;
        sb_q.push_back(ref_model(cur));
      end
    end
  end

  task automatic drain(input string tag);
    int unsigned n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beat_t b;
    bit done;
    rst_l = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(negedge clk);
    check("init_out_valid", out_valid, 0);
    check("init_out_result", out_result, 0);
    check("init_out_flags", out_flags, 0);
    check("init_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run_vec("rne_tie_odd",  mk(0, 127, 24'h800001, 3'b100, 3'd0), 32'h3F800002, 5'h01, 0);
    run_vec("rne_tie_even", mk(0, 127, 24'h800002, 3'b100, 3'd0), 32'h3F800002, 5'h01, 0);
    run_vec("mant_carry",   mk(0, 127, 24'hFFFFFF, 3'b110, 3'd0), 32'h40000000, 5'h01, 0);
    run_vec("ovf_rne",      mk(0, 254, 24'hFFFFFF, 3'b100, 3'd0), 32'h7F800000, 5'h05, 0);
    run_vec("ovf_rup_neg",  mk(1, 255, 24'hFFFFFF, 3'b000, 3'd3), 32'hFF7FFFFF, 5'h05, 0);
    run_vec("ovf_rdn_neg",  mk(1, 255, 24'hFFFFFF, 3'b000, 3'd2), 32'hFF800000, 5'h05, 0);
    run_vec("subn_tiny",    mk(0, 1, 24'h000001, 3'b011, 3'd0), 32'h00000001, 5'h03, 0);
    run_vec("subn_to_norm", mk(0, 1, 24'h7FFFFF, 3'b100, 3'd0), 32'h00800000, 5'h01, 0);
    b = mk(0, 1, 24'h0, 3'b000, 3'd2);
    b.zero = 1;
    run_vec("zero_rdn", b, 32'h80000000, 5'h00, 0);
    run_vec("frm_reserved", mk(0, 127, 24'h800001, 3'b111, 3'd5), 32'h3F800001, 5'h11, 0);

    // Accumulator: idle clear, then 0x01 + 0x04, then clear concurrent with 0x02.
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    @(negedge clk);
    check("acc_clr_idle", flags_acc, 5'h00);
    @(posedge clk); #1;
    run_vec("acc_a", mk(0, 127, 24'h800001, 3'b100, 3'd0), 32'h3F800002, 5'h01, 0);
    b = '0; b.special = 1; b.sres = 32'h7F800000; b.sflags = 5'h04;
    run_vec("acc_b", b, 32'h7F800000, 5'h04, 0);
    @(negedge clk);
    check("acc_or", flags_acc, 5'h05);
    @(posedge clk); #1;
    b = '0; b.special = 1; b.sres = 32'h00000000; b.sflags = 5'h02;
    run_vec("acc_c", b, 32'h00000000, 5'h02, 1);
    @(negedge clk);
    check("acc_clr_hs", flags_acc, 5'h02);
    @(posedge clk); #1;

    // Backpressure: 4 beats into a stalled output.
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send(rand_beat());
    join_none
    repeat (5) @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    drain("stall_drain");

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(rand_beat());
    send(rand_beat());
    rst_l = 1'b0;
    @(negedge clk);
    check("rst_busy_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_flags", out_flags, 0);
      check("rst_flags_acc", flags_acc, 0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and accumulator clears.
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) send(rand_beat());
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom % 4) != 0;
          flags_clr = ($urandom % 16) == 0;
        end
        out_ready = 1'b1;
        flags_clr = 1'b0;
      end
    join
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
